sysref_period_mon: RTL
======================

Name: sysref_period_mon

Overview:
Parametrised SYSREF integrity monitor in the aclk domain. It generalises the free-running clock-frequency counters into a lock-detecting period meter.
- Detects rising edges of the (PL-captured) SYSREF and measures the aclk period between them.
- Tracks min/max period, declares lock after a run of consistent periods, counts glitches, and flags loss of SYSREF.
- Sits between the SYSREF capture register and the RFDC user_sysref input; status is read over the Wishbone register space.

Parameters:
CNT_WIDTH, 16, width of period counter and period/min/max outputs
SYNC_STAGES, 2, synchroniser flops on sysref_i (0 = input already in aclk domain)
LOCK_COUNT, 4, consecutive in-tolerance periods required to assert locked_o (1..255)
TOLERANCE, 0, allowed abs difference (cycles) between consecutive periods
ERR_WIDTH, 8, width of saturating error counter

Ports:
aclk  in  1  stream clock; all logic on rising edge
aresetn  in  1  asynchronous active-low reset
sysref_i  in  1  raw SYSREF level
clear_i  in  1  sync pulse: clear min/max/err_count_o/lost_o, drop lock
edge_o  out  1  1-cycle pulse on each detected rising edge
period_o  out  CNT_WIDTH  last measured period
period_valid_o  out  1  1-cycle pulse when period_o updates
min_o  out  CNT_WIDTH  smallest period since clear
max_o  out  CNT_WIDTH  largest period since clear
locked_o  out  1  period stable
err_count_o  out  ERR_WIDTH  saturating count of out-of-tolerance periods while locked
lost_o  out  1  sticky: counter saturated with no edge

Behaviour:
- Reset (aresetn low, async) values:
  - edge_o=0, period_o=0, period_valid_o=0, min_o=all-ones, max_o=0, locked_o=0, err_count_o=0, lost_o=0.
  - Synchroniser and previous-level flop are 0; FSM is IDLE.
- Edge detect: s = synchronised sysref_i (SYNC_STAGES flops). edge = s & ~s_prev. edge_o registered, so latency from sysref_i = SYNC_STAGES+1 cycles.
- Period definition: cycles between consecutive edge pulses (edges at cycles t0, t1 -> period t1-t0).
  - Counter loads 1 on the edge cycle and increments otherwise.
  - period_o and period_valid_o are registered on the cycle after the edge pulse.
- FSM:
  - IDLE: first edge starts the counter -> ACQ. No period is reported.
  - ACQ: each edge reports a period and updates min/max.
    - If |period - prev_period| <= TOLERANCE, run++; else run=1.
    - When run reaches LOCK_COUNT -> LOCKED and locked_o=1 (same cycle as period_valid_o).
    - The first period in ACQ sets run=1 (no previous period to compare).
  - LOCKED: on an out-of-tolerance period, err_count_o++ (saturates at all-ones, no wrap) -> ACQ with run=1 and locked_o=0.
  - Any state except IDLE: counter reaching all-ones -> lost_o=1, locked_o=0 -> IDLE. The counter holds at all-ones and does not wrap.
- Comparison uses a CNT_WIDTH+1 signed difference; no overflow.
- clear_i:
  - Takes effect next cycle: min/max/err/lost reset; FSM -> IDLE.
  - clear_i coincident with an edge: clear wins; that edge restarts the counter (IDLE->ACQ) and no period is reported.
- Back-to-back edges: minimum period is 2 (level must fall). No special case.
- Reset asserted mid-measurement: all state returns to reset values immediately; nothing is reported.

Optional Feature:
SYSREF_PERIOD_MON_GATE_EN
- Defined:
  - Adds output sysref_gated_o (1 bit).
  - Equals edge_o delayed one cycle, passed only while locked_o=1 and the just-measured period is in tolerance; otherwise 0.
  - Reset value 0. Used to gate user_sysref so glitches never reach the RFDC.
- Undefined: port absent; no extra logic.

Test Plan:
- Reset, then sysref period 64 cycles (high 8) with LOCK_COUNT=4 -> edge_o every 64 cycles at SYNC_STAGES+1 latency; period_o=64; locked_o rises on the 4th period_valid_o; min_o=max_o=64; err_count_o=0.
- While locked, one period of 60 then back to 64, TOLERANCE=0 -> err_count_o=1, locked_o drops at the 60 report and re-asserts after 4 periods of 64; min_o=60; max_o=64 (first 64 after the 60 counts as run=1).
- TOLERANCE=2, periods alternating 63/65 -> locked after 4 periods, err_count_o=0.
- Stop SYSREF with CNT_WIDTH=8 -> lost_o=1 and locked_o=0 at 255 cycles after the last edge; restart -> IDLE, first edge reports nothing.
- Force 300 glitch periods with ERR_WIDTH=8 -> err_count_o saturates at 255; clear_i -> err_count_o=0, min_o=all-ones, max_o=0, lost_o=0.
- aresetn low mid-period and clear_i coincident with an edge -> outputs at reset values immediately; no period_valid_o for the interrupted or cleared period.

Source files
------------

// File: rtl/sysref_period_mon.sv
// SYSREF period/lock monitor: edge_o at SYNC_STAGES+1 cycles, period/lock/min/max one cycle later.
// No backpressure; SYSREF_PERIOD_MON_GATE_EN adds sysref_gated_o (edge_o delayed, passed only while locked).
module sysref_period_mon #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TOLERANCE   = 0,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 sysref_i,
  input  logic                 clear_i,
  output logic                 edge_o,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 period_valid_o,
  output logic [CNT_WIDTH-1:0] min_o,
  output logic [CNT_WIDTH-1:0] max_o,
  output logic                 locked_o,
  output logic [ERR_WIDTH-1:0] err_count_o,
  output logic                 lost_o
`ifdef SYSREF_PERIOD_MON_GATE_EN
  ,
  output logic                 sysref_gated_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_MAX - CNT_ONE;
  localparam logic [CNT_WIDTH:0]   TOL      = (CNT_WIDTH+1)'(TOLERANCE);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX  = '1;
  localparam logic [7:0]           LOCK_N   = 8'(LOCK_COUNT);

  logic w_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = sysref_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= sysref_i;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end
      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  logic                 r_s_prev;
  logic                 r_edge;
  logic [CNT_WIDTH-1:0] r_cnt;
  state_t               r_state;
  logic [7:0]           r_run;
  logic [CNT_WIDTH-1:0] r_prev;
  logic [CNT_WIDTH-1:0] r_period;
  logic                 r_pv;
  logic [CNT_WIDTH-1:0] r_min;
  logic [CNT_WIDTH-1:0] r_max;
  logic                 r_locked;
  logic [ERR_WIDTH-1:0] r_err;
  logic                 r_lost;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_s_prev <= 1'b0;
      r_edge   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s_prev <= w_s;
      r_edge   <= w_s & ~r_s_prev;
      // Counter saturates so a dead SYSREF is seen as lost rather than wrapping.
      if (r_edge) begin
        r_cnt <= CNT_ONE;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  logic signed [CNT_WIDTH:0] w_diff;
  logic        [CNT_WIDTH:0] w_abs;
  logic                      w_have_prev;
  logic                      w_in_tol;

  assign w_diff      = $signed({1'b0, r_cnt}) - $signed({1'b0, r_prev});
  assign w_abs       = w_diff[CNT_WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_have_prev = (r_state == S_LOCKED) || (r_run != 8'd0);
  assign w_in_tol    = w_have_prev && (w_abs <= TOL);

  state_t               w_state_nxt;
  logic [7:0]           w_run_nxt;
  logic [CNT_WIDTH-1:0] w_prev_nxt;
  logic [CNT_WIDTH-1:0] w_period_nxt;
  logic                 w_pv_nxt;
  logic [CNT_WIDTH-1:0] w_min_nxt;
  logic [CNT_WIDTH-1:0] w_max_nxt;
  logic                 w_locked_nxt;
  logic [ERR_WIDTH-1:0] w_err_nxt;
  logic                 w_lost_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_run_nxt    = r_run;
    w_prev_nxt   = r_prev;
    w_period_nxt = r_period;
    w_pv_nxt     = 1'b0;
    w_min_nxt    = r_min;
    w_max_nxt    = r_max;
    w_locked_nxt = r_locked;
    w_err_nxt    = r_err;
    w_lost_nxt   = r_lost;
    if (clear_i) begin
      // A coincident edge still restarts the counter, so go straight to ACQ.
      w_min_nxt    = CNT_MAX;
      w_max_nxt    = '0;
      w_err_nxt    = '0;
      w_lost_nxt   = 1'b0;
      w_locked_nxt = 1'b0;
      w_run_nxt    = 8'd0;
      w_state_nxt  = r_edge ? S_ACQ : S_IDLE;
    end else if (r_edge) begin
      if (r_state == S_IDLE) begin
        w_state_nxt = S_ACQ;
        w_run_nxt   = 8'd0;
      end else begin
        w_period_nxt = r_cnt;
        w_pv_nxt     = 1'b1;
        w_prev_nxt   = r_cnt;
        if (r_cnt < r_min) w_min_nxt = r_cnt;
        if (r_cnt > r_max) w_max_nxt = r_cnt;
        if (r_state == S_LOCKED) begin
          if (!w_in_tol) begin
            if (r_err != ERR_MAX) w_err_nxt = r_err + ERR_WIDTH'(1);
            w_state_nxt  = S_ACQ;
            w_run_nxt    = 8'd1;
            w_locked_nxt = 1'b0;
          end
        end else begin
          w_run_nxt = w_in_tol ? (r_run + 8'd1) : 8'd1;
          if (w_run_nxt == LOCK_N) begin
            w_state_nxt  = S_LOCKED;
            w_locked_nxt = 1'b1;
          end
        end
      end
    end else if ((r_state != S_IDLE) && (r_cnt == CNT_LAST)) begin
      w_lost_nxt   = 1'b1;
      w_locked_nxt = 1'b0;
      w_state_nxt  = S_IDLE;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= S_IDLE;
      r_run    <= 8'd0;
      r_prev   <= '0;
      r_period <= '0;
      r_pv     <= 1'b0;
      r_min    <= CNT_MAX;
      r_max    <= '0;
      r_locked <= 1'b0;
      r_err    <= '0;
      r_lost   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_run    <= w_run_nxt;
      r_prev   <= w_prev_nxt;
      r_period <= w_period_nxt;
      r_pv     <= w_pv_nxt;
      r_min    <= w_min_nxt;
      r_max    <= w_max_nxt;
      r_locked <= w_locked_nxt;
      r_err    <= w_err_nxt;
      r_lost   <= w_lost_nxt;
    end
  end

`ifdef SYSREF_PERIOD_MON_GATE_EN
  logic r_gated;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_gated <= 1'b0;
    end else begin
      r_gated <= r_edge && !clear_i && (r_state != S_IDLE) && w_locked_nxt && w_in_tol;
    end
  end
  assign sysref_gated_o = r_gated;
`endif

  assign edge_o         = r_edge;
  assign period_o       = r_period;
  assign period_valid_o = r_pv;
  assign min_o          = r_min;
  assign max_o          = r_max;
  assign locked_o       = r_locked;
  assign err_count_o    = r_err;
  assign lost_o         = r_lost;

endmodule
